i2c_reg_seq: RTL and testbench

I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

---
 rtl/i2c_reg_seq_pkg.sv | 24 ++
 rtl/i2c_reg_seq.sv | 149 ++++++++++++++
 tb/tb_i2c_reg_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_seq_pkg.sv
// rtl/i2c_reg_seq_pkg.sv - command encodings and command-beat helper for the I2C register sequencer
package i2c_reg_seq_pkg;

    localparam logic [2:0] k_START_CMD   = 3'd1;
    localparam logic [2:0] k_RESTART_CMD = 3'd2;
    localparam logic [2:0] k_STOP_CMD    = 3'd3;
    localparam logic [2:0] k_READ_CMD    = 3'd4;
    localparam logic [2:0] k_WRITE_CMD   = 3'd5;

    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] data;
        logic       nack;
    } cmd_beat_t;

    function automatic cmd_beat_t make_beat(input logic [2:0] c, input logic [7:0] d, input logic n);
        cmd_beat_t b;
        b.cmd  = c;
        b.data = d;
        b.nack = n;
        return b;
    endfunction

endpackage

// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - register read/write sequencer driving a bit-level I2C master
module i2c_reg_seq
    import i2c_reg_seq_pkg::*;
#(
    parameter int NACK_ABORT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_in,
    output logic       req_ready_out,
    input  logic       req_rw_in,
    input  logic [6:0] req_dev_in,
    input  logic [7:0] req_reg_in,
    input  logic [7:0] req_wdata_in,
    output logic       done_out,
    output logic       err_out,
    output logic [7:0] rdata_out,
    output logic [2:0] cmd_out,
    output logic       cmd_valid_out,
    input  logic       cmd_ready_in,
    output logic [7:0] data_out,
    output logic       nack_out,
    input  logic       rsp_valid_in,
    input  logic [7:0] rsp_data_in,
    input  logic       rsp_ack_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_REG, S_WDATA,
        S_RESTART, S_DEV_R, S_RDATA, S_STOP, S_DONE
    } state_t;

    state_t     state;
    state_t     nxt;
    logic       waiting;
    logic       rw;
    logic       err;
    logic       nacked;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    cmd_beat_t  beat;

    function automatic cmd_beat_t beat_for(input state_t s, input logic [6:0] d,
                                           input logic [7:0] r, input logic [7:0] w);
        case (s)
            S_START:   return make_beat(k_START_CMD, 8'h00, 1'b0);
            S_DEV_W:   return make_beat(k_WRITE_CMD, {d, 1'b0}, 1'b0);
            S_REG:     return make_beat(k_WRITE_CMD, r, 1'b0);
            S_WDATA:   return make_beat(k_WRITE_CMD, w, 1'b0);
            S_RESTART: return make_beat(k_RESTART_CMD, 8'h00, 1'b0);
            S_DEV_R:   return make_beat(k_WRITE_CMD, {d, 1'b1}, 1'b0);
            S_RDATA:   return make_beat(k_READ_CMD, 8'h00, 1'b1);
            default:   return make_beat(k_STOP_CMD, 8'h00, 1'b0);
        endcase
    endfunction

    function automatic state_t seq_next(input state_t s, input logic is_read);
        case (s)
            S_START:   return S_DEV_W;
            S_DEV_W:   return S_REG;
            S_REG:     return is_read ? S_RESTART : S_WDATA;
            S_RESTART: return S_DEV_R;
            S_DEV_R:   return S_RDATA;
            default:   return S_STOP;
        endcase
    endfunction

    // Only bytes we transmitted can be NACKed; the ACK bit after READ is our own.
    always_comb begin
        nacked = rsp_ack_in && (state inside {S_DEV_W, S_REG, S_WDATA, S_DEV_R});
        if (state == S_STOP)
            nxt = S_DONE;
        else if (nacked && (NACK_ABORT != 0))
            nxt = S_STOP;
        else
            nxt = seq_next(state, rw);
        beat = beat_for(nxt, dev, reg_addr, wdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            waiting       <= 1'b0;
            rw            <= 1'b0;
            err           <= 1'b0;
            dev           <= 7'h00;
            reg_addr      <= 8'h00;
            wdata         <= 8'h00;
            req_ready_out <= 1'b1;
            cmd_valid_out <= 1'b0;
            cmd_out       <= k_STOP_CMD;
            data_out      <= 8'h00;
            nack_out      <= 1'b0;
            done_out      <= 1'b0;
            err_out       <= 1'b0;
            rdata_out     <= 8'h00;
        end else begin
            done_out <= 1'b0;
            err_out  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_in && req_ready_out) begin
                        rw            <= req_rw_in;
                        dev           <= req_dev_in;
                        reg_addr      <= req_reg_in;
                        wdata         <= req_wdata_in;
                        err           <= 1'b0;
                        req_ready_out <= 1'b0;
                        state         <= S_START;
                        cmd_valid_out <= 1'b1;
                        cmd_out       <= k_START_CMD;
                        data_out      <= 8'h00;
                        nack_out      <= 1'b0;
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    req_ready_out <= 1'b1;
                end
                default: begin
                    if (!waiting) begin
                        if (cmd_ready_in) begin
                            cmd_valid_out <= 1'b0;
                            waiting       <= 1'b1;
                        end
                    end else if (rsp_valid_in) begin
                        waiting <= 1'b0;
                        state   <= nxt;
                        if (nacked)
                            err <= 1'b1;
                        if (state == S_RDATA)
                            rdata_out <= rsp_data_in;
                        if (nxt == S_DONE) begin
                            done_out <= 1'b1;
                            err_out  <= err;
                        end else begin
                            cmd_valid_out <= 1'b1;
                            cmd_out       <= beat.cmd;
                            data_out      <= beat.data;
                            nack_out      <= beat.nack;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb/tb_i2c_reg_seq.sv - directed self-checking bench for i2c_reg_seq
module tb_i2c_reg_seq;
    import i2c_reg_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic [7:0] data;
    logic       nack;
    logic       rsp_valid = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic       rsp_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    // Bench-side master model: logs every accepted command, answers one cycle later.
    logic [2:0] log_cmd  [0:63];
    logic [7:0] log_data [0:63];
    logic       log_nack [0:63];
    int         log_n = 0;
    int         nack_at = -1;
    int         hold_at = -1;
    logic [7:0] rd_byte = 8'h00;

    always #5 clk = ~clk;

    i2c_reg_seq #(.NACK_ABORT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid), .req_ready_out(req_ready), .req_rw_in(req_rw),
        .req_dev_in(req_dev), .req_reg_in(req_reg), .req_wdata_in(req_wdata),
        .done_out(done), .err_out(err), .rdata_out(rdata),
        .cmd_out(cmd), .cmd_valid_out(cmd_valid), .cmd_ready_in(cmd_ready),
        .data_out(data), .nack_out(nack),
        .rsp_valid_in(rsp_valid), .rsp_data_in(rsp_data), .rsp_ack_in(rsp_ack)
    );

    always @(posedge clk) begin
        rsp_valid <= 1'b0;
        if (!rst && cmd_valid && cmd_ready) begin
            if (log_n < 64) begin
                log_cmd[log_n]  <= cmd;
                log_data[log_n] <= data;
                log_nack[log_n] <= nack;
            end
            if (log_n != hold_at) begin
                rsp_valid <= 1'b1;
                rsp_ack   <= (log_n == nack_at);
                rsp_data  <= rd_byte;
            end
            log_n <= log_n + 1;
        end
    end

    task automatic do_req(input logic rw, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_accept: got %b want 1", req_ready);
        end
        req_rw = rw; req_dev = d; req_reg = r; req_wdata = w; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(output int n, output logic got);
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
        checks++; if (cmd !== k_STOP_CMD) begin errors++; $display("FAIL rst_cmd: got %0d want %0d", cmd, k_STOP_CMD); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", data); end
        checks++; if (nack !== 1'b0) begin errors++; $display("FAIL rst_nack: got %b want 0", nack); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write;
        int n, base;
        logic got;
        logic [2:0] ec [0:4];
        logic [7:0] ed [0:4];
        ec = '{k_START_CMD, k_WRITE_CMD, k_WRITE_CMD, k_WRITE_CMD, k_STOP_CMD};
        ed = '{8'h00, 8'hA0, 8'h10, 8'hA5, 8'h00};
        base = log_n;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done(n, got);
        checks++; if (!got) begin errors++; $display("FAIL wr_done_timeout: got none want done"); end
        checks++; if (n != 11) begin errors++; $display("FAIL wr_latency: got %0d want 11", n); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_width: got %b want 0", done); end
        checks++; if (log_n - base != 5) begin errors++; $display("FAIL wr_cmd_count: got %0d want 5", log_n - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_cmd[base+i] !== ec[i] || log_data[base+i] !== ed[i] || log_nack[base+i] !== 1'b0) begin
                errors++;
                $display("FAIL wr_cmd%0d: got cmd=%0d data=%h nack=%b want cmd=%0d data=%h nack=0",
                         i, log_cmd[base+i], log_data[base+i], log_nack[base+i], ec[i], ed[i]);
            end
        end
    endtask

    task automatic test_read;
        int n, base;
        logic got;
        logic [2:0] ec [0:6];
        logic [7:0] ed [0:6];
        logic       en [0:6];
        ec = '{k_START_CMD, k_WRITE_CMD, k_WRITE_CMD, k_RESTART_CMD, k_WRITE_CMD, k_READ_CMD, k_STOP_CMD};
        ed = '{8'h00, 8'hA0, 8'h22, 8'h00, 8'hA1, 8'h00, 8'h00};
        en = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rd_byte = 8'h3C;
        base = log_n;
        do_req(1'b1, 7'h50, 8'h22, 8'hEE);
        wait_done(n, got);
        checks++; if (!got) begin errors++; $display("FAIL rd_done_timeout: got none want done"); end
        checks++; if (n != 15) begin errors++; $display("FAIL rd_latency: got %0d want 15", n); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err); end
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata: got %h want 3c", rdata); end
        checks++; if (log_n - base != 7) begin errors++; $display("FAIL rd_cmd_count: got %0d want 7", log_n - base); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_cmd[base+i] !== ec[i] || log_data[base+i] !== ed[i] || log_nack[base+i] !== en[i]) begin
                errors++;
                $display("FAIL rd_cmd%0d: got cmd=%0d data=%h nack=%b want cmd=%0d data=%h nack=%b",
                         i, log_cmd[base+i], log_data[base+i], log_nack[base+i], ec[i], ed[i], en[i]);
            end
        end
        repeat (2) @(negedge clk);
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata_hold: got %h want 3c", rdata); end
    endtask

    task automatic test_nack_abort;
        int n, base;
        logic got;
        base = log_n;
        nack_at = base + 1;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done(n, got);
        nack_at = -1;
        checks++; if (!got) begin errors++; $display("FAIL nk_done_timeout: got none want done"); end
        checks++; if (n != 7) begin errors++; $display("FAIL nk_latency: got %0d want 7", n); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nk_err: got %b want 1", err); end
        checks++; if (log_n - base != 3) begin errors++; $display("FAIL nk_cmd_count: got %0d want 3", log_n - base); end
        checks++;
        if (log_cmd[base+2] !== k_STOP_CMD) begin
            errors++;
            $display("FAIL nk_after_nack: got cmd=%0d want %0d", log_cmd[base+2], k_STOP_CMD);
        end
    endtask

    task automatic test_stall;
        int n, base, k;
        logic got;
        base = log_n;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5);
        k = 0;
        while (log_n != base + 2 && k < 20) begin @(negedge clk); k++; end
        cmd_ready = 1'b0;
        k = 0;
        while (cmd_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL st_reg_issue: got %b want 1", cmd_valid); end
        req_rw = 1'b1; req_dev = 7'h11; req_reg = 8'h77; req_wdata = 8'h33; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || cmd !== k_WRITE_CMD || data !== 8'h10 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL st_hold%0d: got valid=%b cmd=%0d data=%h ready=%b want 1/%0d/10/0",
                         i, cmd_valid, cmd, data, req_ready, k_WRITE_CMD);
            end
        end
        req_valid = 1'b0;
        cmd_ready = 1'b1;
        wait_done(n, got);
        checks++; if (!got) begin errors++; $display("FAIL st_done_timeout: got none want done"); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL st_err: got %b want 0", err); end
        checks++; if (log_n - base != 5) begin errors++; $display("FAIL st_cmd_count: got %0d want 5", log_n - base); end
        checks++;
        if (log_data[base+2] !== 8'h10 || log_data[base+3] !== 8'hA5) begin
            errors++;
            $display("FAIL st_latched: got reg=%h wdata=%h want 10/a5", log_data[base+2], log_data[base+3]);
        end
        repeat (3) @(negedge clk);
        checks++; if (log_n - base != 5) begin errors++; $display("FAIL st_no_second: got %0d want 5", log_n - base); end
    endtask

    task automatic test_reset_mid;
        int n, base, k;
        logic got;
        base = log_n;
        hold_at = base + 5;
        do_req(1'b1, 7'h50, 8'h22, 8'h00);
        k = 0;
        while (log_n != base + 6 && k < 40) begin @(negedge clk); k++; end
        checks++; if (log_n - base != 6) begin errors++; $display("FAIL rm_reach_rdata: got %0d want 6", log_n - base); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rm_after_rst: got valid=%b ready=%b done=%b want 0/1/0", cmd_valid, req_ready, done);
        end
        @(negedge clk);
        rst = 1'b0;
        hold_at = -1;
        repeat (3) @(negedge clk);
        checks++;
        if (log_n - base != 6 || done !== 1'b0) begin
            errors++;
            $display("FAIL rm_no_stop: got cmds=%0d done=%b want 6/0", log_n - base, done);
        end
        base = log_n;
        do_req(1'b0, 7'h2A, 8'h05, 8'h5A);
        wait_done(n, got);
        checks++; if (!got || n != 11) begin errors++; $display("FAIL rm_fresh_latency: got %0d want 11", n); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_fresh_err: got %b want 0", err); end
        checks++;
        if (log_n - base != 5 || log_data[base+1] !== 8'h54 || log_data[base+2] !== 8'h05 || log_data[base+3] !== 8'h5A) begin
            errors++;
            $display("FAIL rm_fresh_bytes: got n=%0d %h %h %h want 5 54 05 5a",
                     log_n - base, log_data[base+1], log_data[base+2], log_data[base+3]);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_nack_abort;
        test_stall;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
